// File: rtl/irq_pending_latch.sv
// irq_pending_latch: edge/level interrupt capture with mask and a request/ack handshake toward an external priority encoder.
// Optional IRQ_LATCH_SVC_COUNT_EN adds a saturating serviced-request counter svc_count.
module irq_pending_latch #(
  parameter int EDGE_MODE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] irq_in,
  input  logic       mask_we,
  input  logic [3:0] mask_din,
  output logic [3:0] pend,
  input  logic [1:0] enc_y,
  input  logic       enc_valid,
  output logic       irq_req,
  input  logic       irq_ack,
  output logic [1:0] irq_id
`ifdef IRQ_LATCH_SVC_COUNT_EN
  ,
  output logic [7:0] svc_count
`endif
);
  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;
  state_t     state;
  logic [3:0] irq_q, pending, mask, ev, clr;
  logic       acc;
  always_comb begin
    ev   = (EDGE_MODE != 0) ? (irq_in & ~irq_q) : irq_in;
    acc  = (state == REQ) && irq_ack;
    clr  = acc ? (4'b0001 << irq_id) : 4'b0000;
    pend = pending & ~mask;
  end
  // set is OR-ed after the clear so a coincident new event is never lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q   <= '0;
      pending <= '0;
      mask    <= '0;
    end else begin
      irq_q   <= irq_in;
      pending <= (pending & ~clr) | ev;
      if (mask_we) mask <= mask_din;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      irq_req <= 1'b0;
      irq_id  <= 2'b00;
    end else begin
      case (state)
        IDLE: if (enc_valid) begin
          irq_id  <= enc_y;
          irq_req <= 1'b1;
          state   <= REQ;
        end
        REQ: if (irq_ack) begin
          irq_req <= 1'b0;
          state   <= GAP;
        end
        default: begin
          irq_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end
`ifdef IRQ_LATCH_SVC_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) svc_count <= '0;
    else if (acc && svc_count != 8'hff) svc_count <= svc_count + 8'd1;
  end
`endif
endmodule

// File: tb/tb_irq_pending_latch.sv
// tb_irq_pending_latch: directed scoreboard bench for irq_pending_latch with a behavioural 4-to-2 priority encoder.
module tb_irq_pending_latch;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [3:0] irq_in = '0, mask_din = '0, pend;
  logic       mask_we = 1'b0, irq_ack = 1'b0, irq_req, enc_valid;
  logic [1:0] enc_y, irq_id;
`ifdef IRQ_LATCH_SVC_COUNT_EN
  logic [7:0] svc_count;
`endif
  int n_chk = 0, n_fail = 0;
  typedef struct { string tag; logic [7:0] v; } exp_t;
  exp_t sbq[$];

  irq_pending_latch #(.EDGE_MODE(1)) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .mask_we(mask_we), .mask_din(mask_din),
    .pend(pend), .enc_y(enc_y), .enc_valid(enc_valid), .irq_req(irq_req),
    .irq_ack(irq_ack), .irq_id(irq_id)
`ifdef IRQ_LATCH_SVC_COUNT_EN
    , .svc_count(svc_count)
`endif
  );

  always #5 clk = ~clk;
  always_comb begin
    enc_valid = |pend;
    enc_y = pend[3] ? 2'd3 : pend[2] ? 2'd2 : pend[1] ? 2'd1 : 2'd0;
  end

  function automatic logic [7:0] e(logic r, logic [1:0] id, logic [3:0] p);
    return {1'b0, r, id, p};
  endfunction

  task automatic push(string t, logic [7:0] v);
    exp_t x;
    x.tag = t;
    x.v = v;
    sbq.push_back(x);
  endtask

  task automatic chk(logic [7:0] obs);
    exp_t x;
    n_chk++;
    if (sbq.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed %h expected none", obs);
      return;
    end
    x = sbq.pop_front();
    assert (obs === x.v) else begin
      n_fail++;
      $error("FAIL %s observed %h expected %h", x.tag, obs, x.v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(string t, logic [7:0] v);
    push(t, v);
    tick();
    chk({1'b0, irq_req, irq_id, pend});
  endtask

  initial begin
    tick();
    step("reset", e(0, 0, 4'b0000));
    rst_n = 1'b1;
    // single source service
    irq_in = 4'b0100;  step("t1_pend", e(0, 0, 4'b0100));
    irq_in = 4'b0000;  step("t1_req", e(1, 2, 4'b0100));
    irq_ack = 1'b1;    step("t1_ack", e(0, 2, 4'b0000));
    irq_ack = 1'b0;    step("t1_idle", e(0, 2, 4'b0000));
    // two simultaneous sources, priority order
    irq_in = 4'b1010;  step("t2_pend", e(0, 2, 4'b1010));
    irq_in = 4'b0000;  step("t2_req3", e(1, 3, 4'b1010));
    irq_ack = 1'b1;    step("t2_ack3", e(0, 3, 4'b0010));
    irq_ack = 1'b0;    step("t2_gap", e(0, 3, 4'b0010));
    step("t2_req1", e(1, 1, 4'b0010));
    irq_ack = 1'b1;    step("t2_ack1", e(0, 1, 4'b0000));
    irq_ack = 1'b0;    step("t2_idle", e(0, 1, 4'b0000));
    // masking hides but keeps pending
    mask_we = 1'b1; mask_din = 4'b1000; step("t3_mask", e(0, 1, 4'b0000));
    mask_we = 1'b0; irq_in = 4'b1000;   step("t3_hidden", e(0, 1, 4'b0000));
    irq_in = 4'b0000;                   step("t3_noreq", e(0, 1, 4'b0000));
    mask_we = 1'b1; mask_din = 4'b0000; step("t3_unmask", e(0, 1, 4'b1000));
    mask_we = 1'b0;                     step("t3_req3", e(1, 3, 4'b1000));
    mask_we = 1'b1; mask_din = 4'b1000; step("t3_mask_in_req", e(1, 3, 4'b0000));
    mask_we = 1'b0; irq_ack = 1'b1;     step("t3_ack", e(0, 3, 4'b0000));
    irq_ack = 1'b0; mask_we = 1'b1; mask_din = 4'b0000; step("t3_clean", e(0, 3, 4'b0000));
    mask_we = 1'b0;
    // set wins over coincident ack clear
    irq_in = 4'b0100;  step("t4_pend", e(0, 3, 4'b0100));
    irq_in = 4'b0000;  step("t4_req2", e(1, 2, 4'b0100));
    irq_in = 4'b0100; irq_ack = 1'b1; step("t4_setwins", e(0, 2, 4'b0100));
    irq_in = 4'b0000; irq_ack = 1'b0; step("t4_gap", e(0, 2, 4'b0100));
    step("t4_req2b", e(1, 2, 4'b0100));
    irq_in = 4'b1000;  step("t4_hiprio_hold", e(1, 2, 4'b1100));
    irq_in = 4'b0000; irq_ack = 1'b1; step("t4_ack2", e(0, 2, 4'b1000));
    step("t4_ack_in_gap", e(0, 2, 4'b1000));
    step("t4_ack_in_idle", e(1, 3, 4'b1000));
    irq_ack = 1'b0;    step("t4_req3_held", e(1, 3, 4'b1000));
    irq_ack = 1'b1;    step("t4_ack3", e(0, 3, 4'b0000));
    irq_ack = 1'b0;    step("t4_idle", e(0, 3, 4'b0000));
    // asynchronous reset mid-service, level held across release
    irq_in = 4'b0001;  step("t5_pend", e(0, 3, 4'b0001));
    step("t5_req0", e(1, 0, 4'b0001));
    rst_n = 1'b0;
    push("t5_async_rst", e(0, 0, 4'b0000));
    #1 chk({1'b0, irq_req, irq_id, pend});
    step("t5_in_rst", e(0, 0, 4'b0000));
    rst_n = 1'b1;
    step("t5_capture", e(0, 0, 4'b0001));
    step("t5_req", e(1, 0, 4'b0001));
    step("t5_req_held", e(1, 0, 4'b0001));
    irq_ack = 1'b1;    step("t5_ack", e(0, 0, 4'b0000));
    irq_ack = 1'b0;    step("t5_gap", e(0, 0, 4'b0000));
    step("t5_once", e(0, 0, 4'b0000));
    irq_in = 4'b0000;
`ifdef IRQ_LATCH_SVC_COUNT_EN
    push("svc_after_reset", 8'd1);
    chk(svc_count);
    for (int i = 0; i < 300; i++) begin
      irq_in = 4'b0001; tick();
      irq_in = 4'b0000; tick();
      irq_ack = 1'b1;   tick();
      irq_ack = 1'b0;   tick();
    end
    push("svc_saturate", 8'd255);
    chk(svc_count);
`endif
    if (sbq.size() != 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL scoreboard_leftover observed %0d expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
